// File: rtl/uart_rx_fifo.sv
// ZX-Uno UART receive buffer: 16-entry byte FIFO,
// register-read interface and RTS flow control.
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          HIWATER    = 12,
  parameter int          LOWATER    = 4,
  parameter logic [7:0]  ADDR_DATA  = 8'hC6,
  parameter logic [7:0]  ADDR_STAT  = 8'hC7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  output logic [7:0] dout,
  output logic       oe,
  output logic       uart_rts
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HI_CNT   = CW'(HIWATER);
  localparam logic [CW-1:0] LO_CNT   = CW'(LOWATER);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovr;
  logic                  r_rts_halt;
  logic [7:0]            r_snap;
  logic                  r_snap_valid;
  logic                  r_sel_data;
  logic                  r_clr_ovr;
  logic                  r_regrd_d;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_is_data;
  logic                  w_is_stat;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovr_set;
  logic                  w_ovr_clr;
  logic [CW-1:0]         w_count_next;
  logic [7:0]            w_stat;
  logic [7:0]            w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_is_data = (zxuno_addr == ADDR_DATA);
  assign w_is_stat = (zxuno_addr == ADDR_STAT);
  assign w_rise    = zxuno_regrd & ~r_regrd_d;
  assign w_fall    = ~zxuno_regrd & r_regrd_d;

  // A pop needs a data read whose snapshot really held a byte.
  assign w_pop     = w_fall & r_sel_data & r_snap_valid;

  // A pop in the same cycle frees the slot a full FIFO lacks.
  assign w_push    = rx_valid & (~w_full | w_pop);
  assign w_ovr_set = rx_valid & w_full & ~w_pop;
  assign w_ovr_clr = w_fall & r_clr_ovr;

  assign w_head    = r_mem[r_rptr];
  assign w_stat    = {~w_empty, r_ovr, w_full, 5'(r_count)};

  // Next occupancy, used for both the count and RTS.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + ONE_CNT;
      2'b01:   w_count_next = r_count - ONE_CNT;
      default: w_count_next = r_count;
    endcase
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= rx_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ONE_PTR;
      end
      r_count <= w_count_next;
    end
  end

  // Sticky overrun; a fresh overrun beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end else if (w_ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  // RTS hysteresis on the occupancy about to be stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rts_halt <= 1'b0;
    end else if (w_count_next >= HI_CNT) begin
      r_rts_halt <= 1'b1;
    end else if (w_count_next <= LO_CNT) begin
      r_rts_halt <= 1'b0;
    end
  end

  // Read strobe delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regrd_d <= 1'b0;
    end else begin
      r_regrd_d <= zxuno_regrd;
    end
  end

  // Freeze the read value and the operation at the read rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap       <= 8'h00;
      r_snap_valid <= 1'b0;
      r_sel_data   <= 1'b0;
      r_clr_ovr    <= 1'b0;
    end else if (w_rise) begin
      r_sel_data <= w_is_data;
      r_clr_ovr  <= w_is_stat & r_ovr;
      if (w_is_data) begin
        r_snap       <= w_empty ? 8'h00 : w_head;
        r_snap_valid <= ~w_empty;
      end else if (w_is_stat) begin
        r_snap       <= w_stat;
        r_snap_valid <= 1'b0;
      end else begin
        r_snap_valid <= 1'b0;
      end
    end else if (w_fall) begin
      r_snap_valid <= 1'b0;
      r_clr_ovr    <= 1'b0;
    end
  end

  assign oe       = zxuno_regrd & (w_is_data | w_is_stat);
  assign dout     = r_snap;
  assign uart_rts = r_rts_halt;

endmodule
